// File: rtl/trace_pkg.sv
// Shared definitions for the write-back commit-trace recorder: the
// observable state encoding and the packed entry layout {ts, pc, reg, data}.
package trace_pkg;

  // Encoding is visible on the state port: 0=IDLE 1=ARMED 2=POST 3=FROZEN.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StPost   = 2'd2,
    StFrozen = 2'd3
  } trace_state_e;

  // Overflow counter width when the overwrite counter is built in.
  localparam int unsigned OvfW = 16;

  // Entry packing, MSB to LSB: timestamp, pc, register, data.
  function automatic int unsigned entry_width(input int unsigned ts_w, input int unsigned pc_w,
                                              input int unsigned reg_w,
                                              input int unsigned data_w);
    return ts_w + pc_w + reg_w + data_w;
  endfunction

  function automatic int unsigned reg_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned pc_lsb(input int unsigned reg_w, input int unsigned data_w);
    return data_w + reg_w;
  endfunction

  function automatic int unsigned ts_lsb(input int unsigned pc_w, input int unsigned reg_w,
                                         input int unsigned data_w);
    return data_w + reg_w + pc_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: Depth x Width register array, one synchronous write port
// and one asynchronous read port. Contents are not reset.
module trace_ram #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 61
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Write port: one entry per enabled cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port is combinational so the head entry is visible in the same cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back commit-trace recorder. Captures {ts, pc, reg, data} of each
// commit while armed into a circular buffer, freezes a programmable number
// of commits after a PC-match or forced trigger, then drains oldest-first
// over a valid/ready port.
// Optional: define TRACE_OVF_CNT_EN to add the ovf_count output, a
// saturating count of commits that overwrote an unread entry.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_valid,
  input  logic [REG_AW-1:0]        commit_reg,
  input  logic [DATA_W-1:0]        commit_data,
  input  logic [PC_W-1:0]          commit_pc,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     trig_en,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic                     force_trig,
  input  logic [$clog2(DEPTH)-1:0] post_cnt,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [TS_W-1:0]          rd_ts,
  output logic [PC_W-1:0]          rd_pc,
  output logic [REG_AW-1:0]        rd_reg,
  output logic [DATA_W-1:0]        rd_data
`ifdef TRACE_OVF_CNT_EN
  ,
  output logic [OvfW-1:0]          ovf_count
`endif
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned EntryW = entry_width(TS_W, PC_W, REG_AW, DATA_W);
  localparam int unsigned RegLsb = reg_lsb(DATA_W);
  localparam int unsigned PcLsb  = pc_lsb(REG_AW, DATA_W);
  localparam int unsigned TsLsb  = ts_lsb(PC_W, REG_AW, DATA_W);
  localparam logic [AW:0] FillMax = (AW + 1)'(DEPTH);

  trace_state_e state_q, state_d;

  logic [TS_W-1:0] ts_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   post_q, post_d;
  logic [AW:0]     fill_q, fill_d;
  logic [AW-1:0]   rd_ptr;

  logic            recording;
  logic            trigger;
  logic            wr_en;
  logic            rd_fire;
  logic            arm_go;
  logic            rd_valid_int;

  logic [EntryW-1:0] wr_entry;
  logic [EntryW-1:0] rd_entry;

  assign recording = (state_q == StArmed) || (state_q == StPost);
  // Triggers only count while ARMED; POST ignores further triggers.
  assign trigger   = (state_q == StArmed) &&
                     (force_trig || (trig_en && commit_valid && (commit_pc == trig_pc)));
  assign wr_en     = recording && commit_valid && !abort;
  assign arm_go    = (state_q == StIdle) && arm && !abort;
  assign rd_valid_int = (state_q == StFrozen) && (fill_q != '0);
  assign rd_fire   = rd_valid_int && rd_ready && !abort;

  // Oldest entry sits fill_count slots behind the write pointer.
  assign rd_ptr    = wr_ptr_q - fill_q[AW-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) state_d = StArmed;
        end
        StArmed: begin
          if (trigger) state_d = (post_cnt == '0) ? StFrozen : StPost;
        end
        StPost: begin
          if (commit_valid && (post_q == AW'(1))) state_d = StFrozen;
        end
        StFrozen: begin
          // Leaves one cycle after the last accept, or at once if frozen empty.
          if (fill_q == '0) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Status and handshake outputs.
  always_comb begin
    state      = state_q;
    fill_count = fill_q;
    rd_valid   = rd_valid_int;
  end

  // Next values for write pointer, fill level and post-trigger counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    post_d   = post_q;
    if (abort) begin
      fill_d = '0;
    end else begin
      if (arm_go) begin
        wr_ptr_d = '0;
        fill_d   = '0;
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        // At capacity the oldest entry is overwritten; level stays at DEPTH.
        if (fill_q != FillMax) fill_d = fill_q + (AW + 1)'(1);
      end
      if (trigger) begin
        post_d = post_cnt;
      end else if ((state_q == StPost) && commit_valid) begin
        post_d = post_q - AW'(1);
      end
      if (rd_fire) begin
        fill_d = fill_q - (AW + 1)'(1);
      end
    end
  end

  // Pointer, level and post-trigger counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      post_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      post_q   <= post_d;
    end
  end

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

`ifdef TRACE_OVF_CNT_EN
  logic [OvfW-1:0] ovf_q;

  // Saturating count of commits that displaced an unread entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= '0;
    end else if (abort || arm_go) begin
      ovf_q <= '0;
    end else if (wr_en && (fill_q == FillMax) && (ovf_q != '1)) begin
      ovf_q <= ovf_q + OvfW'(1);
    end
  end

  assign ovf_count = ovf_q;
`endif

  assign wr_entry = {ts_q, commit_pc, commit_reg, commit_data};

  trace_ram #(
    .Depth(DEPTH),
    .Width(EntryW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_entry),
    .raddr_i(rd_ptr),
    .rdata_o(rd_entry)
  );

  assign rd_data = rd_entry[DATA_W-1:0];
  assign rd_reg  = rd_entry[RegLsb +: REG_AW];
  assign rd_pc   = rd_entry[PcLsb +: PC_W];
  assign rd_ts   = rd_entry[TsLsb +: TS_W];

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed scenarios followed by
// randomized traffic, all compared each cycle against a queue-based model.
// Honours TRACE_OVF_CNT_EN to also check ovf_count.
module tb_wb_trace_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned PC_W   = 8;
  localparam int unsigned TS_W   = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              commit_valid;
  logic [REG_AW-1:0] commit_reg;
  logic [DATA_W-1:0] commit_data;
  logic [PC_W-1:0]   commit_pc;
  logic              arm;
  logic              abort;
  logic              trig_en;
  logic [PC_W-1:0]   trig_pc;
  logic              force_trig;
  logic [AW-1:0]     post_cnt;
  logic [1:0]        state;
  logic [AW:0]       fill_count;
  logic              rd_valid;
  logic              rd_ready;
  logic [TS_W-1:0]   rd_ts;
  logic [PC_W-1:0]   rd_pc;
  logic [REG_AW-1:0] rd_reg;
  logic [DATA_W-1:0] rd_data;
`ifdef TRACE_OVF_CNT_EN
  logic [15:0]       ovf_count;
`endif

  always #5 clk = ~clk;

  wb_trace_buffer #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW),
    .PC_W  (PC_W),
    .TS_W  (TS_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .commit_valid(commit_valid),
    .commit_reg  (commit_reg),
    .commit_data (commit_data),
    .commit_pc   (commit_pc),
    .arm         (arm),
    .abort       (abort),
    .trig_en     (trig_en),
    .trig_pc     (trig_pc),
    .force_trig  (force_trig),
    .post_cnt    (post_cnt),
    .state       (state),
    .fill_count  (fill_count),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_ts       (rd_ts),
    .rd_pc       (rd_pc),
    .rd_reg      (rd_reg),
    .rd_data     (rd_data)
`ifdef TRACE_OVF_CNT_EN
    ,
    .ovf_count   (ovf_count)
`endif
  );

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [PC_W-1:0]   pc;
    logic [REG_AW-1:0] rg;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference model: trace as a bounded queue, oldest at index 0.
  ent_t            m_q[$];
  int              m_state;
  int              m_post;
  int              m_ovf;
  logic [TS_W-1:0] m_ts;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_push(input ent_t e);
    if (m_q.size() == DEPTH) begin
      void'(m_q.pop_front());
      if (m_ovf < 65535) m_ovf++;
    end
    m_q.push_back(e);
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    ent_t e;
    bit   trig;
    if (!rst) begin
      m_state = 0;
      m_q.delete();
      m_post  = 0;
      m_ovf   = 0;
      m_ts    = '0;
      return;
    end
    e.ts   = m_ts;
    e.pc   = commit_pc;
    e.rg   = commit_reg;
    e.data = commit_data;
    if (abort) begin
      m_state = 0;
      m_q.delete();
      m_ovf = 0;
    end else begin
      case (m_state)
        0: if (arm) begin
          m_state = 1;
          m_q.delete();
          m_ovf = 0;
        end
        1: begin
          trig = force_trig || (trig_en && commit_valid && (commit_pc == trig_pc));
          if (commit_valid) model_push(e);
          if (trig) begin
            m_post  = int'(post_cnt);
            m_state = (m_post == 0) ? 3 : 2;
          end
        end
        2: if (commit_valid) begin
          model_push(e);
          m_post--;
          if (m_post == 0) m_state = 3;
        end
        default: begin
          if (m_q.size() == 0) m_state = 0;
          else if (rd_ready) void'(m_q.pop_front());
        end
      endcase
    end
    m_ts = m_ts + TS_W'(1);
  endtask

  task automatic compare_all();
    bit head;
    head = (m_state == 3) && (m_q.size() > 0);
    check_eq("state", 64'(state), 64'(m_state));
    check_eq("fill_count", 64'(fill_count), 64'(m_q.size()));
    check_eq("rd_valid", 64'(rd_valid), 64'(head));
    if (head) begin
      check_eq("rd_ts", 64'(rd_ts), 64'(m_q[0].ts));
      check_eq("rd_pc", 64'(rd_pc), 64'(m_q[0].pc));
      check_eq("rd_reg", 64'(rd_reg), 64'(m_q[0].rg));
      check_eq("rd_data", 64'(rd_data), 64'(m_q[0].data));
    end
`ifdef TRACE_OVF_CNT_EN
    check_eq("ovf_count", 64'(ovf_count), 64'(m_ovf));
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    commit_valid = 1'b0;
    arm          = 1'b0;
    abort        = 1'b0;
    force_trig   = 1'b0;
    rd_ready     = 1'b0;
    trig_en      = 1'b0;
  endtask

  task automatic set_commit(input int rg, input int data, input int pc);
    commit_valid = 1'b1;
    commit_reg   = REG_AW'(rg);
    commit_data  = DATA_W'(data);
    commit_pc    = PC_W'(pc);
  endtask

  task automatic drain_to_idle(input string tag);
    for (int i = 0; i < 40 && state != 2'd0; i++) tick();
    check_eq(tag, 64'(state), 64'd0);
  endtask

  logic [PC_W-1:0] exp_pcs [6];
  int idx;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    exp_pcs[0] = 8'h20; exp_pcs[1] = 8'h24; exp_pcs[2] = 8'h28;
    exp_pcs[3] = 8'h2C; exp_pcs[4] = 8'h30; exp_pcs[5] = 8'h34;
    rst = 1'b0;
    idle_in();
    trig_pc  = '0;
    post_cnt = '0;
    set_commit(3, 32'h1234, 8'h10);
    arm = 1'b1;

    // Reset held with commits and arm present.
    tick();
    tick();
    check_eq("rst_fill", 64'(fill_count), 64'd0);
    rst = 1'b1;
    arm = 1'b0;
    repeat (3) tick();
    check_eq("noarm_fill", 64'(fill_count), 64'd0);

    // Basic capture, forced trigger without a commit.
    idle_in();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_commit(i, 10 * i, 8'h80 + i);
      tick();
    end
    commit_valid = 1'b0;
    force_trig   = 1'b1;
    tick();
    force_trig = 1'b0;
    check_eq("basic_state", 64'(state), 64'd3);
    check_eq("basic_fill", 64'(fill_count), 64'd5);
    rd_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      check_eq("basic_reg", 64'(rd_reg), 64'(k));
      tick();
    end
    drain_to_idle("basic_idle");

    // Wrap: 20 commits, PC match on the 20th with no post-trigger commits.
    idle_in();
    arm = 1'b1;
    tick();
    arm      = 1'b0;
    trig_en  = 1'b1;
    trig_pc  = 8'd20;
    post_cnt = '0;
    for (int i = 1; i <= 20; i++) begin
      set_commit(i % 32, i, i);
      tick();
    end
    idle_in();
    check_eq("wrap_state", 64'(state), 64'd3);
    check_eq("wrap_fill", 64'(fill_count), 64'd16);
`ifdef TRACE_OVF_CNT_EN
    check_eq("wrap_ovf", 64'(ovf_count), 64'd4);
`endif
    rd_ready = 1'b1;
    for (int k = 5; k <= 20; k++) begin
      check_eq("wrap_data", 64'(rd_data), 64'(k));
      tick();
    end
    drain_to_idle("wrap_idle");

    // Post-trigger window with random backpressure on readout.
    idle_in();
    arm = 1'b1;
    tick();
    arm      = 1'b0;
    trig_en  = 1'b1;
    trig_pc  = 8'h24;
    post_cnt = 4'd3;
    for (int i = 0; i < 6; i++) begin
      set_commit(i + 1, 100 + i, int'(exp_pcs[i]));
      tick();
      if (i == 4) check_eq("post_frozen", 64'(state), 64'd3);
    end
    idle_in();
    check_eq("post_fill", 64'(fill_count), 64'd5);
    idx = 0;
    for (int i = 0; i < 60 && state != 2'd0; i++) begin
      rd_ready = 1'($urandom_range(0, 1));
      if (rd_valid && rd_ready && idx < 6) begin
        check_eq("post_pc", 64'(rd_pc), 64'(exp_pcs[idx]));
        idx++;
      end
      tick();
    end
    check_eq("post_count", 64'(idx), 64'd5);
    check_eq("post_idle", 64'(state), 64'd0);

    // Abort during readout.
    idle_in();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_commit(i, 7 * i, 8'h40 + i);
      tick();
    end
    commit_valid = 1'b0;
    force_trig   = 1'b1;
    tick();
    force_trig = 1'b0;
    rd_ready   = 1'b1;
    tick();
    rd_ready = 1'b0;
    abort    = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_state", 64'(state), 64'd0);
    check_eq("abort_valid", 64'(rd_valid), 64'd0);

    // Arm with a simultaneous commit, then abort together with a trigger.
    idle_in();
    arm = 1'b1;
    set_commit(9, 99, 8'h55);
    tick();
    idle_in();
    check_eq("armcommit_fill", 64'(fill_count), 64'd0);
    set_commit(1, 1, 8'h60);
    tick();
    trig_en    = 1'b1;
    trig_pc    = 8'h61;
    force_trig = 1'b1;
    abort      = 1'b1;
    set_commit(2, 2, 8'h61);
    tick();
    idle_in();
    check_eq("abort_trig_state", 64'(state), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 299) != 0);
      arm          = ($urandom_range(0, 15) == 0);
      abort        = ($urandom_range(0, 79) == 0);
      commit_valid = 1'($urandom_range(0, 1));
      commit_reg   = REG_AW'($urandom);
      commit_data  = $urandom;
      commit_pc    = PC_W'($urandom_range(0, 15));
      trig_pc      = PC_W'($urandom_range(0, 15));
      trig_en      = ($urandom_range(0, 3) == 0);
      force_trig   = ($urandom_range(0, 47) == 0);
      post_cnt     = AW'($urandom);
      rd_ready     = 1'($urandom_range(0, 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Hardware commit-trace recorder for the pipelined processor; taps the write-back stage (write-enable, destination register, write data) plus a PC tag.
- Records commits into a parametrised circular buffer while armed, then freezes on a PC-match or forced trigger after a programmable post-trigger count.
- Drains entries oldest-first over a valid/ready port.
- Replaces per-cycle signal printing with a synthesizable, on-chip observability block.

Parameters:
- DATA_W, 32, width of write-back data.
- REG_AW, 5, register address width.
- PC_W, 8, PC/tag width.
- TS_W, 16, timestamp counter width.
- DEPTH, 16, buffer entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 at a rising edge resets).
- commit_valid  in  1  write-back RegWrite.
- commit_reg  in  REG_AW  write-back destination register.
- commit_data  in  DATA_W  write-back data.
- commit_pc  in  PC_W  PC tag of the committing instruction.
- arm  in  1  start-recording pulse.
- abort  in  1  return to IDLE from any state.
- trig_en  in  1  enable PC-match trigger.
- trig_pc  in  PC_W  trigger PC.
- force_trig  in  1  immediate trigger.
- post_cnt  in  $clog2(DEPTH)  commits recorded after the trigger commit.
- state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=FROZEN.
- fill_count  out  $clog2(DEPTH)+1  valid entries held.
- rd_valid  out  1  readout entry available.
- rd_ready  in  1  consumer accepts the entry.
- rd_ts  out  TS_W  entry timestamp.
- rd_pc  out  PC_W  entry PC.
- rd_reg  out  REG_AW  entry register.
- rd_data  out  DATA_W  entry data.

Behaviour:
- Reset values: state=IDLE, all pointers 0, fill_count=0, rd_valid=0, timestamp=0, post counter 0.
- Reset leaves array contents undefined; rd_* outputs are don't-care while rd_valid=0.
- Timestamp: free-running, increments every cycle out of reset, wraps at 2^TS_W. Each entry stores the timestamp value of the cycle its commit was recorded.
- IDLE:
  - arm=1 -> ARMED next cycle; wr_ptr and fill_count cleared.
  - A commit in the same cycle as arm is not recorded.
- ARMED:
  - Each commit_valid writes {ts, pc, reg, data} at wr_ptr. wr_ptr increments modulo DEPTH; fill_count saturates at DEPTH, and the oldest entry is overwritten.
  - Trigger = force_trig OR (trig_en AND commit_valid AND commit_pc==trig_pc). A commit that triggers is itself recorded.
  - On trigger, post counter loads post_cnt. If post_cnt==0 -> FROZEN, else -> POST.
  - force_trig with no commit that cycle records nothing.
- POST:
  - Each commit is recorded and decrements the post counter; the commit that brings it to 0 moves the block to FROZEN.
  - Further triggers are ignored.
  - post_cnt is sampled only at trigger time; max DEPTH-1, so the trigger entry always survives.
- FROZEN:
  - Commits are ignored. rd_ptr = wr_ptr - fill_count (mod DEPTH).
  - rd_valid=1 while fill_count>0. rd_* show the entry at rd_ptr combinationally, in the same cycle.
  - rd_valid AND rd_ready: rd_ptr++, fill_count--.
  - When fill_count reaches 0 -> IDLE on the following cycle. A trace frozen with fill_count=0 goes straight to IDLE.
  - rd_* must hold stable while rd_valid=1 and rd_ready=0.
  - arm is ignored.
- abort: highest priority after reset; from any state -> IDLE, fill_count=0, rd_valid=0 next cycle.
- Priority per cycle: rst > abort > state-machine actions.

Optional Feature:
- TRACE_OVF_CNT_EN:
  - When defined, adds output ovf_count (16 bits). It counts commits that overwrote an unread entry (ARMED/POST with fill_count==DEPTH), saturates at 0xFFFF, clears on arm, reset and abort.
  - When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package trace_pkg: state encoding constants (IDLE/ARMED/POST/FROZEN) and the entry field order/widths as localparams derived from the parameters.
- One natural sub-module, trace_ram: a DEPTH x (TS_W+PC_W+REG_AW+DATA_W) register array with one synchronous write port and one asynchronous read port.
- Control FSM, pointers and timestamp stay in wb_trace_buffer.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles with commits present -> state=0, fill_count=0, rd_valid=0; release, commits without arm -> nothing recorded.
- Basic capture:
  - Stimulus: arm; 5 commits (reg 1..5, data 10..50); force_trig with no commit.
  - Response: FROZEN, fill_count=5; readout with rd_ready=1 yields reg 1..5 in order with increasing rd_ts; IDLE after the last accept.
- Wrap:
  - Stimulus: DEPTH=16, 20 commits (data 1..20); PC-match trigger on commit 20 with post_cnt=0.
  - Response: fill_count=16; readout data 5..20; with TRACE_OVF_CNT_EN, ovf_count=4.
- Post-trigger:
  - Stimulus: trig_pc=0x24, post_cnt=3; commits with pc 0x20, 0x24, 0x28, 0x2C, 0x30, 0x34.
  - Response: freezes after the 0x30 commit; last entry pc=0x30; 0x34 is not recorded.
- Backpressure/abort:
  - Stimulus: in FROZEN toggle rd_ready 0/1.
  - Response: rd_* stable when not accepted; no entry is skipped or duplicated.
  - Stimulus: abort mid-readout.
  - Response: IDLE next cycle, rd_valid=0.
- Simultaneous:
  - Stimulus: arm with a commit in the same cycle.
  - Response: that commit is not recorded.
  - Stimulus: abort and trigger in the same cycle.
  - Response: IDLE.
